// File: rtl/mmio_uart_tx.sv
// MMIO peripheral on the core's data port: LED register, TX FIFO and 8N1
// serializer, with readback of status and baud divisor.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_DEFAULT = 234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  led,
  output logic        tx,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          sel;
  logic [1:0]    off;
  logic          wr;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic          empty;
  logic          ovf;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [15:0]   div;
  logic [15:0]   bdiv;
  logic [15:0]   cnt;
  logic [7:0]    shift;
  logic [2:0]    bidx;
  state_t        state;
  logic          unused;

  assign sel     = addr[7];
  assign off     = addr[1:0];
  assign wr      = we & sel;
  assign push    = wr & (off == 2'd1);
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign push_ok = push & (~full | pop);
  assign unused  = ^{addr[31:8], addr[6:2], wdata[31:16]};

  // Pop happens wherever the serializer loads a new frame.
  assign pop = ~empty & ((state == IDLE) |
                         ((state == STOP) & (cnt == '0)));

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push_ok & ~pop) count <= count + 1'b1;
      else if (~push_ok & pop) count <= count - 1'b1;
      if (push & full & ~pop) ovf <= 1'b1;
      else if (wr & (off == 2'd2) & wdata[3]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
      div <= 16'(DIV_DEFAULT);
    end else begin
      if (wr & (off == 2'd0)) led <= wdata[7:0];
      if (wr & (off == 2'd3))
        div <= (wdata[15:0] == '0) ? 16'd1 : wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      cnt   <= '0;
      bdiv  <= 16'd1;
      shift <= '0;
      bidx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rptr];
            bdiv  <= div;
            cnt   <= div - 1'b1;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == '0) begin
            state <= DATA;
            tx    <= shift[0];
            bidx  <= '0;
            cnt   <= bdiv - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= bdiv - 1'b1;
            if (bidx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift <= shift >> 1;
              tx    <= shift[1];
              bidx  <= bidx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (pop) begin
            shift <= mem[rptr];
            bdiv  <= div;
            cnt   <= div - 1'b1;
            state <= START;
            tx    <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (off)
        2'd0: rdata = {24'b0, led};
        2'd1: rdata = '0;
        2'd2: rdata = {28'b0, ovf, busy, empty, full};
        2'd3: rdata = {16'b0, div};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register vectors plus frame,
// overflow, divisor and mid-frame reset sequences.
module tb_mmio_uart_tx;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic        tx;
  logic        busy;

  int tests;
  int fails;

  mmio_uart_tx #(.FIFO_DEPTH(4), .DIV_DEFAULT(234)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .led(led), .tx(tx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rexp;
    logic [7:0]  lexp;
  } vec_t;

  vec_t v [9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    return b[pos-1];
  endfunction

  initial begin
    logic [31:0] r;
    logic [7:0]  bytes;
    bit          bad;
    tests = 0;
    fails = 0;
    we = 0;
    addr = 0;
    wdata = 0;

    v[0] = '{1'b1, 32'h80, 32'h1A5,   32'h80, 32'hA5,   8'hA5};
    v[1] = '{1'b1, 32'h84, 32'h3C,    32'h80, 32'h3C,   8'h3C};
    v[2] = '{1'b1, 32'h00, 32'hFF,    32'h00, 32'h0,    8'h3C};
    v[3] = '{1'b0, 32'h80, 32'h77,    32'h80, 32'h3C,   8'h3C};
    v[4] = '{1'b1, 32'h83, 32'h4,     32'h83, 32'h4,    8'h3C};
    v[5] = '{1'b1, 32'hFF, 32'h12345, 32'h83, 32'h2345, 8'h3C};
    v[6] = '{1'b1, 32'h83, 32'h0,     32'h87, 32'h1,    8'h3C};
    v[7] = '{1'b1, 32'h83, 32'h4,     32'h81, 32'h0,    8'h3C};
    v[8] = '{1'b0, 32'h82, 32'h0,     32'h82, 32'h2,    8'h3C};

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_led", 32'(led), 32'h0);
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    read(32'h82, r);
    check("rst_status", r, 32'h2);
    read(32'h83, r);
    check("rst_div", r, 32'd234);

    // register vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      we = v[i].we;
      addr = v[i].addr;
      wdata = v[i].wdata;
      @(posedge clk);
      #1;
      we = 1'b0;
      read(v[i].raddr, r);
      check($sformatf("vec%0d_rdata", i), r, v[i].rexp);
      check($sformatf("vec%0d_led", i), 32'(led), 32'(v[i].lexp));
    end

    // single frame, DIV=4, byte 0x55
    write(32'h81, 32'h55);
    read(32'h82, r);
    check("frame_status_k", r, 32'h0);
    for (int j = 1; j <= 44; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) begin
        read(32'h82, r);
        check("frame_status_k1", r, 32'h6);
      end
      check($sformatf("frame_tx%0d", j), 32'(tx),
            32'(exp_bit(8'h55, (j - 1) / 4)));
      if (j == 40) check("frame_busy40", 32'(busy), 32'h1);
      if (j == 41) check("frame_busy41", 32'(busy), 32'h0);
    end

    // overflow: 0x01..0x06 back to back
    for (int i = 1; i <= 6; i++) write(32'h81, 32'(i));
    read(32'h82, r);
    check("ovf_status", r, 32'hD);
    write(32'h82, 32'h8);
    read(32'h82, r);
    check("ovf_clear", r, 32'h5);
    for (int c = 6; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c < 200) begin
        bytes = 8'(c / 40 + 1);
        check($sformatf("ovf_tx%0d", c), 32'(tx),
              32'(exp_bit(bytes, (c % 40) / 4)));
      end
      if (c == 199) check("ovf_busy199", 32'(busy), 32'h1);
      if (c == 200) check("ovf_busy200", 32'(busy), 32'h0);
    end
    read(32'h82, r);
    check("ovf_drained", r, 32'h2);

    // divisor 0 -> 1, then DIV=8 mid-frame
    write(32'h83, 32'h0);
    read(32'h83, r);
    check("div0_read", r, 32'h1);
    write(32'h81, 32'hA3);
    write(32'h81, 32'h3C);
    write(32'h83, 32'h8);
    for (int c = 2; c <= 90; c++) begin
      @(posedge clk);
      #1;
      if (c < 10)
        check($sformatf("div1_tx%0d", c), 32'(tx),
              32'(exp_bit(8'hA3, c)));
      else if (c < 90)
        check($sformatf("div8_tx%0d", c), 32'(tx),
              32'(exp_bit(8'h3C, (c - 10) / 8)));
      if (c == 89) check("div8_busy89", 32'(busy), 32'h1);
      if (c == 90) check("div8_busy90", 32'(busy), 32'h0);
    end

    // reset mid-frame with bytes queued
    write(32'h83, 32'h4);
    write(32'h81, 32'h11);
    write(32'h81, 32'h22);
    write(32'h81, 32'h33);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_tx", 32'(tx), 32'h1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    read(32'h82, r);
    check("mid_rst_status", r, 32'h2);
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("mid_rst_quiet", 32'(bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
